touch_uart_rx: RTL
==================

// Module: touch_uart_rx
// PURPOSE
//  Receives the touchscreen controller's serial stream on GPIO_1[31] and decodes 5-byte pen reports.
//  Each decoded report becomes one (pen, x, y) event, buffered in a small FIFO.
//  The buffered events are read by the HPS over an Avalon-MM slave.
//  Sits upstream of the HPS whiteboard software, as a custom component in the cpu system on clk_clk.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        9600        line rate; 16x oversample tick = CLK_HZ/(16*BAUD), rounded down
//  FIFO_DEPTH  8           event FIFO entries, power of two, >= 2
// PORTS
//  clk           in   1   system clock (one clock domain)
//  reset_n       in   1   asynchronous, active-low reset
//  uart_rxd      in   1   serial input, idle high, 8N1, asynchronous to clk
//  avs_address   in   2   word address: 0 STATUS, 1 DATA, 2 CONTROL, 3 reserved (reads 0)
//  avs_read      in   1   read strobe
//  avs_write     in   1   write strobe
//  avs_writedata in   32  write data
//  avs_readdata  out  32  read data, registered; valid 1 cycle after avs_read
//  irq           out  1   interrupt, present only with TOUCH_IRQ_EN
// BEHAVIOUR
//  Reset: avs_readdata=0, irq=0, FIFO empty, overflow=0, irq_en=0, UART in IDLE, parser in HUNT.
//  Input conditioning: uart_rxd passes through a 2-flop synchronizer.
//  UART: falling edge in IDLE -> START.
//   At tick 8 the line is sampled again; if high, the start is false -> IDLE.
//   Data bits are sampled every 16 ticks from there, LSB first, then STOP.
//   Stop=1 -> byte_valid pulses for one cycle. Stop=0 -> framing error: byte dropped, parser forced to HUNT.
//  Parser states: HUNT, XLO, XHI, YLO, YHI.
//   Header byte = bit7 set. It is accepted in any state: pen<=bit0, state goes to XLO.
//   Data byte (bit7=0) in HUNT is ignored.
//   XLO: x[6:0]. XHI: x[11:7]=byte[4:0]. YLO: y[6:0]. YHI: y[11:7] -> push event, state goes to HUNT.
//  Event word: {pen[31], 3'b0, y[27:16], 4'b0, x[11:0]}.
//  STATUS read: bit0 = not empty, bit1 = overflow (sticky), bits[15:8] = FIFO count.
//  STATUS write: writing 1 to bit1 clears overflow.
//  DATA read, FIFO not empty: returns the head event and pops it, exactly one pop per avs_read cycle.
//  DATA read, FIFO empty: returns 0, no pop, no error.
//  CONTROL write: bit0=1 flushes the FIFO (self-clearing); bit1 sets irq_en.
//  CONTROL read: returns {30'b0, irq_en, 1'b0}.
//  Push when full and no pop in the same cycle: event dropped, overflow<=1.
//  Push and pop in the same cycle when full: both happen, no overflow.
//  Flush and push in the same cycle: flush wins, the pushed event is discarded.
//  Latency: last stop-bit sample to FIFO push is at most 2 cycles.
//  Reset asserted mid-byte or mid-packet: all state is lost, no partial event is pushed.
// CONFIGURATION
//  TOUCH_IRQ_EN defined: port irq = irq_en & (not empty | overflow), registered.
//  TOUCH_IRQ_EN undefined: no irq port; CONTROL bit1 is writable and reads back, but has no other effect.
// STRUCTURE
//  touch_pkg: register addresses, STATUS/CONTROL bit indices, header mask 8'h80, event field offsets.
//  Sub-module uart_rx_core: synchronizer, tick divider, UART FSM; outputs byte[7:0], byte_valid, frame_err.
//  Top level: parser FSM, FIFO (register array with pointers), Avalon-MM register decode.
// TESTING
//  1. Send 80,10,05,20,03 (8N1) -> STATUS=0x0101; DATA=0x01A00290 (pen0, y=0x1A0, x=0x290); STATUS=0x0000.
//  2. Send 81,7F,1F,7F,1F -> DATA=0x8FFF0FFF.
//     Then send 81,01,80,00,00,00,00 -> exactly one event, 0x00000000 (the re-sync header is used).
//  3. Send 9 complete packets, no reads -> count=8, overflow=1.
//     Eight DATA reads return packets 1..8; write STATUS=0x2 -> overflow=0.
//  4. Send byte with stop=0 mid-packet, then a full packet -> one event, the valid packet only.
//     A glitch low for 4 ticks produces no byte.
//  5. Queue 3 events, write CONTROL=0x1 -> STATUS=0. DATA read on empty -> 0, count stays 0.
//  6. TOUCH_IRQ_EN defined: CONTROL=0x2, push one event -> irq=1; DATA read -> irq=0 next cycle.
//     Pulse reset_n low mid-byte -> all outputs at reset values, no event.

Source files
------------

// File: rtl/touch_pkg.sv
// touch_pkg: shared constants and state types for the touchscreen UART receiver.
//   - Avalon-MM word addresses (STATUS, DATA, CONTROL; address 3 reads 0)
//   - STATUS / CONTROL bit indices
//   - pen-report header mask and event word field offsets
//   - UART and report-parser state types
package touch_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_DATA    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int unsigned STAT_NE_BIT    = 0;
    localparam int unsigned STAT_OVF_BIT   = 1;
    localparam int unsigned STAT_CNT_LSB   = 8;
    localparam int unsigned CTRL_FLUSH_BIT = 0;
    localparam int unsigned CTRL_IRQEN_BIT = 1;

    localparam logic [7:0] HDR_MASK = 8'h80;

    localparam int unsigned EV_PEN_BIT = 31;
    localparam int unsigned EV_Y_LSB   = 16;
    localparam int unsigned EV_X_LSB   = 0;
    localparam int unsigned EV_COORD_W = 12;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic [2:0] {
        P_HUNT,
        P_XLO,
        P_XHI,
        P_YLO,
        P_YHI
    } parse_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 16x oversampling.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   rxd        in   serial line, idle high, asynchronous to clk
//   rx_byte    out  last received byte (valid while byte_valid is high)
//   byte_valid out  one-cycle pulse: byte received with a good stop bit
//   frame_err  out  one-cycle pulse: stop bit sampled low, byte discarded
module uart_rx_core
    import touch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned DIV_RAW = CLK_HZ / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned DW      = $clog2(DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          rxd_meta;
    logic          rxd_s;
    logic          rxd_d;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    uart_state_t   state;

    // Divider is held in IDLE so tick phase is aligned to the detected start edge.
    always_comb begin
        tick = (state != U_IDLE) && (div_cnt == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta   <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_d      <= 1'b1;
            div_cnt    <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            state      <= U_IDLE;
        end else begin
            rxd_meta   <= rxd;
            rxd_s      <= rxd_meta;
            rxd_d      <= rxd_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == U_IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                U_IDLE: begin
                    // Edge, not level: a line stuck low after a framing error
                    // does not re-trigger until it has returned high.
                    if (rxd_d && !rxd_s) begin
                        os_cnt <= '0;
                        state  <= U_START;
                    end
                end
                U_START: begin
                    if (tick) begin
                        if (os_cnt == 4'd7) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= rxd_s ? U_IDLE : U_DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                U_DATA: begin
                    if (tick) begin
                        if (os_cnt == 4'd15) begin
                            os_cnt <= '0;
                            shreg  <= {rxd_s, shreg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= U_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                U_STOP: begin
                    if (tick) begin
                        if (os_cnt == 4'd15) begin
                            os_cnt <= '0;
                            state  <= U_IDLE;
                            if (rxd_s) begin
                                rx_byte    <= shreg;
                                byte_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                default: state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/touch_uart_rx.sv
// touch_uart_rx: touchscreen serial receiver, 5-byte pen report decoder,
// event FIFO and Avalon-MM slave for the HPS.
// Optional build macro: TOUCH_IRQ_EN adds the irq output.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   uart_rxd      in   serial input, 8N1, idle high
//   avs_address   in   0 STATUS, 1 DATA, 2 CONTROL, 3 reserved (reads 0)
//   avs_read      in   read strobe
//   avs_write     in   write strobe
//   avs_writedata in   write data
//   avs_readdata  out  registered read data, valid one cycle after avs_read
//   irq           out  (TOUCH_IRQ_EN only) irq_en & (not empty | overflow)
module touch_uart_rx
    import touch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rxd,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata
`ifdef TOUCH_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]   rx_byte;
    logic         byte_valid;
    logic         frame_err;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (uart_rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    parse_state_t pstate;
    logic         pen;
    logic [11:0]  x_acc;
    logic [6:0]   y_lo;
    logic         is_header;
    logic         push;
    logic [31:0]  push_word;

    // The final byte is merged combinationally so the push lands on the
    // same edge the parser consumes it.
    always_comb begin
        is_header = (rx_byte & HDR_MASK) != 8'h00;
        push      = byte_valid && !is_header && (pstate == P_YHI);
        push_word = '0;
        push_word[EV_PEN_BIT]               = pen;
        push_word[EV_Y_LSB +: EV_COORD_W]   = {rx_byte[4:0], y_lo};
        push_word[EV_X_LSB +: EV_COORD_W]   = x_acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pstate <= P_HUNT;
            pen    <= 1'b0;
            x_acc  <= '0;
            y_lo   <= '0;
        end else if (frame_err) begin
            pstate <= P_HUNT;
        end else if (byte_valid) begin
            if (is_header) begin
                pen    <= rx_byte[0];
                pstate <= P_XLO;
            end else begin
                case (pstate)
                    P_XLO: begin
                        x_acc[6:0] <= rx_byte[6:0];
                        pstate     <= P_XHI;
                    end
                    P_XHI: begin
                        x_acc[11:7] <= rx_byte[4:0];
                        pstate      <= P_YLO;
                    end
                    P_YLO: begin
                        y_lo   <= rx_byte[6:0];
                        pstate <= P_YHI;
                    end
                    P_YHI:   pstate <= P_HUNT;
                    default: pstate <= P_HUNT;
                endcase
            end
        end
    end

    logic [31:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;
    logic [AW:0]  count_nxt;
    logic         overflow;
    logic         ovf_nxt;
    logic         irq_en;
    logic         irq_en_nxt;
    logic         empty;
    logic         full;
    logic         pop;
    logic         flush;
    logic         do_push;
    logic         wr_status;
    logic         wr_control;
    logic [31:0]  status_word;
    logic [31:0]  rd_word;
    logic         unused_wdata;

    assign unused_wdata = ^avs_writedata[31:2];

    always_comb begin
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        wr_status  = avs_write && (avs_address == ADDR_STATUS);
        wr_control = avs_write && (avs_address == ADDR_CONTROL);
        pop        = avs_read && (avs_address == ADDR_DATA) && !empty;
        flush      = wr_control && avs_writedata[CTRL_FLUSH_BIT];
        do_push    = push && !flush && (!full || pop);

        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !do_push) begin
            count_nxt = count - 1'b1;
        end

        // A dropped push beats a same-cycle clear so the loss stays visible.
        ovf_nxt = overflow;
        if (wr_status && avs_writedata[STAT_OVF_BIT]) begin
            ovf_nxt = 1'b0;
        end
        if (push && !flush && full && !pop) begin
            ovf_nxt = 1'b1;
        end

        irq_en_nxt = wr_control ? avs_writedata[CTRL_IRQEN_BIT] : irq_en;

        status_word = '0;
        status_word[STAT_NE_BIT]              = !empty;
        status_word[STAT_OVF_BIT]             = overflow;
        status_word[STAT_CNT_LSB +: (AW + 1)] = count;

        case (avs_address)
            ADDR_STATUS:  rd_word = status_word;
            ADDR_DATA:    rd_word = empty ? '0 : mem[rd_ptr];
            ADDR_CONTROL: rd_word = {30'b0, irq_en, 1'b0};
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            irq_en       <= 1'b0;
            avs_readdata <= '0;
        end else begin
            count    <= count_nxt;
            overflow <= ovf_nxt;
            irq_en   <= irq_en_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end
            if (avs_read) begin
                avs_readdata <= rd_word;
            end
        end
    end

`ifdef TOUCH_IRQ_EN
    // Built from next-state values so irq moves on the same edge as the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en_nxt && ((count_nxt != '0) || ovf_nxt);
        end
    end
`endif

endmodule
